// File: rtl/mem_sp_param_if.sv
// Request/response bus for mem_sp_param.
// The requester drives the master side. The memory sits on the slave side.
interface mem_sp_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [DATA_WIDTH/8-1:0]   req_be;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_sp_param.sv
// Parametrised single-port synchronous RAM with a valid/ready request port,
// byte write enables, selectable read-during-write behaviour, an optional
// output register and a zero-clear sweeper.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | sweeping zeros over every word, one per cycle; port stalled
// ST_RUN   | accepting one request per cycle
module mem_sp_param #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 13,
    parameter int DEPTH          = 8192,
    parameter int OUT_REG        = 0,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clka,
    input  logic             rsta_n,
    mem_sp_param_if.slave    bus,
    input  logic             clear,
    output logic             busy
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    CLR_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       clr_addr;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   accept;
    logic                   in_range;
    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  old_word;
    logic [DATA_WIDTH-1:0]  merged_word;
    logic [DATA_WIDTH-1:0]  rsp_word;

    logic                   mem_we;
    logic [IDX_W-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    logic                   s1_valid;
    logic [DATA_WIDTH-1:0]  s1_rdata;
    logic                   s1_err;

    // Ready and busy are pure state decodes so a requester can rely on
    // ready without any combinational path from its own valid.
    assign bus.req_ready = (state == ST_RUN);
    assign busy          = (state == ST_CLEAR);

    assign accept   = bus.req_valid && bus.req_ready;
    assign in_range = {1'b0, bus.req_addr} < DEPTH_L;
    assign idx      = bus.req_addr[IDX_W-1:0];
    assign old_word = mem[idx];

    // Merge the enabled bytes of the write data over the stored word.
    always_comb begin
        merged_word = old_word;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (bus.req_be[b]) begin
                merged_word[8*b +: 8] = bus.req_wdata[8*b +: 8];
            end
        end
    end

    // Read-first returns the pre-write word, write-first the merged word.
    assign rsp_word = ((WRITE_MODE != 0) && bus.req_we) ? merged_word : old_word;

    // Single write port shared between the sweeper and accepted writes;
    // the two never coincide because the port is stalled during a sweep.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = idx;
        mem_wdata = merged_word;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = '0;
        end else if (accept && bus.req_we && in_range) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; contents survive reset, only a sweep zeroes them.
    always_ff @(posedge clka) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Sequencer: sweep after reset (optional) or on a clear pulse in RUN.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == CLR_LAST) begin
                        state    <= ST_RUN;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + IDX_W'(1);
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // First response stage: data only updates on an accepted request so the
    // last response word is held between beats.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            s1_valid <= 1'b0;
            s1_rdata <= '0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_err   <= accept && !in_range;
            if (accept) begin
                s1_rdata <= in_range ? rsp_word : '0;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_rdata;
            logic                  s2_err;

            // Optional output pipeline stage, same hold behaviour as stage one.
            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    s2_valid <= 1'b0;
                    s2_rdata <= '0;
                    s2_err   <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    if (s1_valid) begin
                        s2_rdata <= s1_rdata;
                    end
                end
            end

            assign bus.rsp_valid = s2_valid;
            assign bus.rsp_rdata = s2_rdata;
            assign bus.rsp_err   = s2_err;
        end else begin : g_no_out_reg
            assign bus.rsp_valid = s1_valid;
            assign bus.rsp_rdata = s1_rdata;
            assign bus.rsp_err   = s1_err;
        end
    endgenerate

endmodule
